// File: rtl/kv_pkg.sv
// Shared encodings for the key/value store command initiator: op codes, status codes,
// store command encodings and the initiator state enum.
package kv_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_OPEN   = 2'd1,
        OP_CREDIT = 2'd2,
        OP_DEBIT  = 2'd3
    } kv_op_e;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_NOT_FOUND    = 3'd1,
        ST_INSUFFICIENT = 3'd2,
        ST_OVERFLOW     = 3'd3,
        ST_DUPLICATE    = 3'd4,
        ST_BAD_KEY      = 3'd5
    } kv_status_e;

    typedef enum logic [1:0] {
        SIG_SEARCH   = 2'd0,
        SIG_INSERT   = 2'd1,
        SIG_TRANSACT = 2'd2
    } kv_signal_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP1   = 3'd1,
        S_LOOKUP = 3'd2,
        S_DECIDE = 3'd3,
        S_GAP2   = 3'd4,
        S_EXEC   = 3'd5,
        S_RESP   = 3'd6
    } kv_state_e;

    // Searching the reserved key is the bus idle pattern; the store answers it with address 0.
    localparam logic [31:0] IDLE_KEY    = 32'd0;
    localparam int          TIMER_WIDTH = 16;

    function automatic logic credit_overflows(input logic [31:0] balance,
                                              input logic [31:0] amount);
        logic [32:0] sum;
        sum = {1'b0, balance} + {1'b0, amount};
        return sum[32];
    endfunction

endpackage

// File: rtl/kv_hold_timer.sv
// Loadable down-counter used to hold the store command bus stable for a fixed number
// of cycles; done_o flags the last cycle of the loaded interval.
module kv_hold_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded on entry to a hold state, so a count of 1 marks that state's final cycle.
    assign done_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/kv_txn_initiator.sv
// Command initiator for the cuckoo-hash key/value store: lookup, decide, then execute,
// with a valid/ready request port and a held valid/ready response port.
module kv_txn_initiator
    import kv_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int GAP_CYCLES    = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [31:0]          req_key_i,
    input  logic [31:0]          req_amount_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [2:0]           rsp_status_o,
    output logic [31:0]          rsp_value_o,
    output logic [31:0]          rsp_addr_o,
    output logic                 kv_ram_enable_o,
    output logic                 kv_write_enable_o,
    output logic [1:0]           kv_signal_o,
    output logic [31:0]          kv_key_o,
    output logic [31:0]          kv_value_o,
    output logic [31:0]          kv_transact_value_o,
    output logic                 kv_transact_kind_o,
    input  logic [31:0]          kv_value_addr_i,
    input  logic [31:0]          kv_updated_value_i,
    output logic [CNT_WIDTH-1:0] txn_count_o,
    output logic [CNT_WIDTH-1:0] reject_count_o
);

    // state  | meaning
    // IDLE   | waiting for a request, bus idle
    // GAP1   | idle pattern before the lookup
    // LOOKUP | search of the request key held stable
    // DECIDE | classify lookup result, reject or go execute
    // GAP2   | idle pattern before the execute command
    // EXEC   | insert or transact held stable, write enable high
    // RESP   | response held until accepted

    localparam logic [TIMER_WIDTH-1:0] GAP_LD    = TIMER_WIDTH'(GAP_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] SETTLE_LD = TIMER_WIDTH'(SETTLE_CYCLES);

    kv_state_e             state_q, state_d;
    kv_op_e                op_q, op_d;
    logic [31:0]           key_q, key_d;
    logic [31:0]           amt_q, amt_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           bal_q, bal_d;
    kv_status_e            status_q, status_d;
    logic [31:0]           value_q, value_d;
    logic [31:0]           raddr_q, raddr_d;
    logic [CNT_WIDTH-1:0]  txn_q, txn_d;
    logic [CNT_WIDTH-1:0]  rej_q, rej_d;

    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_val;
    logic                   timer_done;

    kv_hold_timer #(
        .WIDTH(TIMER_WIDTH)
    ) u_hold_timer (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .done_o     (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        key_d      = key_q;
        amt_d      = amt_q;
        addr_d     = addr_q;
        bal_d      = bal_q;
        status_d   = status_q;
        value_d    = value_q;
        raddr_d    = raddr_q;
        txn_d      = txn_q;
        rej_d      = rej_q;
        timer_load = 1'b0;
        timer_val  = SETTLE_LD;

        kv_write_enable_o   = 1'b0;
        kv_signal_o         = SIG_SEARCH;
        kv_key_o            = IDLE_KEY;
        kv_value_o          = 32'd0;
        kv_transact_value_o = 32'd0;
        kv_transact_kind_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d  = kv_op_e'(req_op_i);
                    key_d = req_key_i;
                    amt_d = req_amount_i;
                    if (req_key_i == IDLE_KEY) begin
                        status_d = ST_BAD_KEY;
                        value_d  = 32'd0;
                        raddr_d  = 32'd0;
                        state_d  = S_RESP;
                    end else begin
                        timer_load = 1'b1;
                        timer_val  = GAP_LD;
                        state_d    = S_GAP1;
                    end
                end
            end
            S_GAP1: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_val  = SETTLE_LD;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                kv_signal_o = SIG_SEARCH;
                kv_key_o    = key_q;
                if (timer_done) begin
                    addr_d  = kv_value_addr_i;
                    bal_d   = kv_updated_value_i;
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                value_d = bal_q;
                raddr_d = addr_q;
                state_d = S_RESP;
                case (op_q)
                    OP_LOOKUP: status_d = (addr_q != 32'd0) ? ST_OK : ST_NOT_FOUND;
                    OP_OPEN: begin
                        if (addr_q != 32'd0) begin
                            status_d = ST_DUPLICATE;
                        end else begin
                            state_d = S_GAP2;
                        end
                    end
                    OP_CREDIT: begin
                        if (addr_q == 32'd0) begin
                            status_d = ST_NOT_FOUND;
                        end else if (credit_overflows(bal_q, amt_q)) begin
                            status_d = ST_OVERFLOW;
                        end else begin
                            state_d = S_GAP2;
                        end
                    end
                    default: begin
                        if (addr_q == 32'd0) begin
                            status_d = ST_NOT_FOUND;
                        end else if (amt_q > bal_q) begin
                            status_d = ST_INSUFFICIENT;
                        end else begin
                            state_d = S_GAP2;
                        end
                    end
                endcase
                if (state_d == S_GAP2) begin
                    timer_load = 1'b1;
                    timer_val  = GAP_LD;
                end
            end
            S_GAP2: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_val  = SETTLE_LD;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                kv_write_enable_o = 1'b1;
                kv_key_o          = key_q;
                if (op_q == OP_OPEN) begin
                    kv_signal_o = SIG_INSERT;
                    kv_value_o  = amt_q;
                end else begin
                    kv_signal_o         = SIG_TRANSACT;
                    kv_transact_value_o = amt_q;
                    kv_transact_kind_o  = (op_q == OP_CREDIT);
                end
                // An OPEN only learns its slot address from the insert itself.
                if (timer_done) begin
                    value_d  = kv_updated_value_i;
                    raddr_d  = kv_value_addr_i;
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                    if (status_q == ST_OK) begin
                        txn_d = (&txn_q) ? txn_q : txn_q + 1'b1;
                    end else begin
                        rej_d = (&rej_q) ? rej_q : rej_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            op_q     <= OP_LOOKUP;
            key_q    <= 32'd0;
            amt_q    <= 32'd0;
            addr_q   <= 32'd0;
            bal_q    <= 32'd0;
            status_q <= ST_OK;
            value_q  <= 32'd0;
            raddr_q  <= 32'd0;
            txn_q    <= '0;
            rej_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            key_q    <= key_d;
            amt_q    <= amt_d;
            addr_q   <= addr_d;
            bal_q    <= bal_d;
            status_q <= status_d;
            value_q  <= value_d;
            raddr_q  <= raddr_d;
            txn_q    <= txn_d;
            rej_q    <= rej_d;
        end
    end

    assign kv_ram_enable_o = ~reset_i;
    assign req_ready_o     = (state_q == S_IDLE);
    assign rsp_valid_o     = (state_q == S_RESP);
    assign rsp_status_o    = status_q;
    assign rsp_value_o     = value_q;
    assign rsp_addr_o      = raddr_q;
    assign txn_count_o     = txn_q;
    assign reject_count_o  = rej_q;

endmodule

// File: tb/tb_kv_txn_initiator.sv
// Directed bench for kv_txn_initiator against a small behavioural key/value store.
module tb_kv_txn_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0]  req_op;
    logic [31:0] req_key, req_amount;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_value, rsp_addr;
    logic        kv_en, kv_we, kv_kind;
    logic [1:0]  kv_sig;
    logic [31:0] kv_key, kv_val, kv_tv, kv_addr, kv_upd;
    logic [15:0] txn_cnt, rej_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kv_txn_initiator #(.SETTLE_CYCLES(4), .GAP_CYCLES(1), .CNT_WIDTH(16)) dut (
        .clock_i(clk), .reset_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_key_i(req_key), .req_amount_i(req_amount),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_status_o(rsp_status),
        .rsp_value_o(rsp_value), .rsp_addr_o(rsp_addr),
        .kv_ram_enable_o(kv_en), .kv_write_enable_o(kv_we), .kv_signal_o(kv_sig),
        .kv_key_o(kv_key), .kv_value_o(kv_val), .kv_transact_value_o(kv_tv),
        .kv_transact_kind_o(kv_kind), .kv_value_addr_i(kv_addr),
        .kv_updated_value_i(kv_upd),
        .txn_count_o(txn_cnt), .reject_count_o(rej_cnt)
    );

    // Behavioural store: 7 slots, address = slot index, key 0 never matches.
    logic [31:0] skey [1:7];
    logic [31:0] sval [1:7];
    logic [7:1]  sused = '0;
    logic        applied = 1'b0;
    logic [31:0] free_idx;

    always_comb begin
        kv_addr  = 32'd0;
        kv_upd   = 32'd0;
        free_idx = 32'd0;
        for (int i = 7; i >= 1; i--) begin
            if (!sused[i]) free_idx = i;
        end
        for (int i = 1; i <= 7; i++) begin
            if (sused[i] && skey[i] == kv_key && kv_key != 32'd0) begin
                kv_addr = i;
                kv_upd  = sval[i];
            end
        end
    end

    always @(posedge clk) begin
        if (!kv_we) begin
            applied <= 1'b0;
        end else if (!applied) begin
            applied <= 1'b1;
            if (kv_sig == 2'd1 && kv_addr == 32'd0 && free_idx != 32'd0) begin
                sused[free_idx[2:0]] <= 1'b1;
                skey[free_idx[2:0]]  <= kv_key;
                sval[free_idx[2:0]]  <= kv_val;
            end else if (kv_sig == 2'd2 && kv_addr != 32'd0) begin
                sval[kv_addr[2:0]] <= kv_kind ? sval[kv_addr[2:0]] + kv_tv
                                              : sval[kv_addr[2:0]] - kv_tv;
            end
        end
    end

    // Bus activity counters, sampled each edge; tests compare before/after snapshots.
    int ins_seen = 0, trans_seen = 0, cmd_seen = 0;
    always @(posedge clk) begin
        if (kv_sig == 2'd1) ins_seen++;
        if (kv_sig == 2'd2) trans_seen++;
        if (kv_sig != 2'd0 || kv_key != 32'd0 || kv_we) cmd_seen++;
    end

    logic [2:0]  r_st;
    logic [31:0] r_val, r_addr;
    int          r_lat;

    task automatic send_req(input logic [1:0] op, input logic [31:0] key, input logic [31:0] amt);
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = op;
        req_key    = key;
        req_amount = amt;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        r_lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r_lat = c;
                break;
            end
        end
        r_st   = rsp_status;
        r_val  = rsp_value;
        r_addr = rsp_addr;
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if ({rsp_status, rsp_value, rsp_addr} !== 67'd0) begin errors++; $display("FAIL reset_rsp_fields got %0d/%0d/%0d want 0/0/0", rsp_status, rsp_value, rsp_addr); end
        checks++; if (txn_cnt !== 16'd0 || rej_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", txn_cnt, rej_cnt); end
        checks++; if ({kv_sig, kv_key, kv_val, kv_tv, kv_kind, kv_we} !== 100'd0) begin errors++; $display("FAIL reset_idle_bus sig %0d key %0d we %b want all 0", kv_sig, kv_key, kv_we); end
        checks++; if (kv_en !== 1'b1) begin errors++; $display("FAIL reset_ram_enable got %b want 1", kv_en); end
    endtask

    task automatic test_open();
        send_req(2'd1, 32'd5, 32'd100);
        wait_rsp();
        checks++; if (r_st !== 3'd0) begin errors++; $display("FAIL open_status got %0d want 0", r_st); end
        checks++; if (r_val !== 32'd100) begin errors++; $display("FAIL open_value got %0d want 100", r_val); end
        checks++; if (r_addr !== 32'd1) begin errors++; $display("FAIL open_addr got %0d want 1", r_addr); end
        checks++; if (r_lat !== 12) begin errors++; $display("FAIL open_latency got %0d want 12", r_lat); end
        ack_rsp();
        @(negedge clk);
        checks++; if (txn_cnt !== 16'd1) begin errors++; $display("FAIL open_txn_count got %0d want 1", txn_cnt); end
    endtask

    task automatic test_duplicate();
        int ins0;
        ins0 = ins_seen;
        send_req(2'd1, 32'd5, 32'd999);
        wait_rsp();
        checks++; if (r_st !== 3'd4) begin errors++; $display("FAIL dup_status got %0d want 4", r_st); end
        checks++; if (r_val !== 32'd100) begin errors++; $display("FAIL dup_value got %0d want 100", r_val); end
        checks++; if (ins_seen !== ins0) begin errors++; $display("FAIL dup_no_insert got %0d insert cycles want 0", ins_seen - ins0); end
        ack_rsp();
    endtask

    task automatic test_credit_debit();
        int tr0;
        send_req(2'd2, 32'd5, 32'd50);
        wait_rsp();
        checks++; if (r_st !== 3'd0 || r_val !== 32'd150) begin errors++; $display("FAIL credit_result got %0d/%0d want 0/150", r_st, r_val); end
        ack_rsp();
        tr0 = trans_seen;
        send_req(2'd3, 32'd5, 32'd200);
        wait_rsp();
        checks++; if (r_st !== 3'd2 || r_val !== 32'd150) begin errors++; $display("FAIL debit_insufficient got %0d/%0d want 2/150", r_st, r_val); end
        checks++; if (trans_seen !== tr0) begin errors++; $display("FAIL debit_no_transact got %0d cycles want 0", trans_seen - tr0); end
        checks++; if (r_lat !== 7) begin errors++; $display("FAIL reject_latency got %0d want 7", r_lat); end
        ack_rsp();
        send_req(2'd3, 32'd5, 32'd150);
        wait_rsp();
        checks++; if (r_st !== 3'd0 || r_val !== 32'd0) begin errors++; $display("FAIL debit_exact got %0d/%0d want 0/0", r_st, r_val); end
        ack_rsp();
        send_req(2'd2, 32'd5, 32'd150);
        wait_rsp();
        checks++; if (r_st !== 3'd0 || r_val !== 32'd150) begin errors++; $display("FAIL credit_back got %0d/%0d want 0/150", r_st, r_val); end
        ack_rsp();
    endtask

    task automatic test_not_found_overflow();
        send_req(2'd0, 32'd7, 32'd0);
        wait_rsp();
        checks++; if (r_st !== 3'd1 || r_addr !== 32'd0) begin errors++; $display("FAIL lookup_absent got %0d/%0d want 1/0", r_st, r_addr); end
        ack_rsp();
        send_req(2'd2, 32'd5, 32'hFFFF_FFF0);
        wait_rsp();
        checks++; if (r_st !== 3'd3 || r_val !== 32'd150) begin errors++; $display("FAIL credit_overflow got %0d/%0d want 3/150", r_st, r_val); end
        ack_rsp();
    endtask

    task automatic test_back_pressure();
        int bad;
        bad = 0;
        send_req(2'd0, 32'd5, 32'd0);
        wait_rsp();
        checks++; if (r_st !== 3'd0 || r_val !== 32'd150 || r_addr !== 32'd1) begin errors++; $display("FAIL lookup_hit got %0d/%0d/%0d want 0/150/1", r_st, r_val, r_addr); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_status !== 3'd0
                || rsp_value !== 32'd150 || rsp_addr !== 32'd1 || kv_key !== 32'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable got %0d unstable cycles want 0", bad); end
        ack_rsp();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stall_release got valid %b ready %b want 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_bad_key();
        int cmd0;
        cmd0 = cmd_seen;
        send_req(2'd2, 32'd0, 32'd10);
        wait_rsp();
        checks++; if (r_st !== 3'd5) begin errors++; $display("FAIL bad_key_status got %0d want 5", r_st); end
        checks++; if (cmd_seen !== cmd0) begin errors++; $display("FAIL bad_key_no_cmd got %0d cmd cycles want 0", cmd_seen - cmd0); end
        ack_rsp();
        @(negedge clk);
        checks++; if (txn_cnt !== 16'd5 || rej_cnt !== 16'd5) begin errors++; $display("FAIL counters got %0d/%0d want 5/5", txn_cnt, rej_cnt); end
    endtask

    task automatic test_reset_in_exec();
        logic hit;
        hit = 1'b0;
        send_req(2'd2, 32'd5, 32'd1);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (kv_we) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL exec_reached got %b want 1", hit); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({kv_sig, kv_key, kv_tv, kv_we} !== 67'd0) begin errors++; $display("FAIL abort_idle_bus sig %0d key %0d we %b want 0", kv_sig, kv_key, kv_we); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL abort_handshake got valid %b ready %b want 0 1", rsp_valid, req_ready); end
        checks++; if (txn_cnt !== 16'd0 || rej_cnt !== 16'd0) begin errors++; $display("FAIL abort_counters got %0d/%0d want 0/0", txn_cnt, rej_cnt); end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_key    = 32'd0;
        req_amount = 32'd0;
        rsp_ready  = 1'b0;
        test_reset();
        test_open();
        test_duplicate();
        test_credit_debit();
        test_not_found_overflow();
        test_back_pressure();
        test_bad_key();
        test_reset_in_exec();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
